// File: rtl/lenet_pkg.sv
// Shared LeNet accelerator definitions: kernel geometry, load FSM states
// and the tap-counter width helper.
package lenet_pkg;

  localparam int LENET_KERNAL_SIZE = 5;
  localparam int KERNEL_TAPS       = LENET_KERNAL_SIZE * LENET_KERNAL_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } load_state_e;

  function automatic int tap_cnt_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/wm_addr_gen.sv
// Weight-memory address generator: kernel base = index*taps, then one
// address per advance until the tap counter reaches its terminal value.
module wm_addr_gen
  import lenet_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int KIDX_WIDTH = 3,
  parameter int TAPS       = KERNEL_TAPS,
  parameter int CNT_WIDTH  = tap_cnt_width(KERNEL_TAPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [KIDX_WIDTH-1:0] kernel_idx_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  assign last_o = (cnt_q == CNT_WIDTH'(TAPS - 1));
  assign addr_o = addr_q;

  // The counter stops at the terminal tap so the address never runs into the next kernel.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (start_i) begin
      cnt_d  = '0;
      addr_d = ADDR_WIDTH'(kernel_idx_i) * ADDR_WIDTH'(TAPS);
    end else if (advance_i && !last_o) begin
      cnt_d  = cnt_q + CNT_WIDTH'(1);
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/wm_fifo_load_ctrl.sv
// Loads one conv kernel from weight memory into the 25-tap weight shift FIFO.
// Optional WM_CHECKSUM_EN adds a wrapping sum of the shifted weights.
module wm_fifo_load_ctrl
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNAL_SIZE = LENET_KERNAL_SIZE,
  parameter int NUM_KERNELS = 6,
  parameter int ADDR_WIDTH  = 8,
  parameter int KIDX_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_req_i,
  input  logic [KIDX_WIDTH-1:0] kernel_idx_i,
  output logic                  load_busy_o,
  output logic                  load_done_o,
  output logic                  req_err_o,
  output logic                  weights_valid_o,
  output logic [KIDX_WIDTH-1:0] loaded_idx_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  fifo_enable_o,
  output logic [DATA_WIDTH-1:0] fifo_data_in_o
`ifdef WM_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] load_checksum_o
`endif
);

  localparam int TAPS = KERNAL_SIZE * KERNAL_SIZE;
  localparam logic [KIDX_WIDTH:0] NUM_K = (KIDX_WIDTH + 1)'(NUM_KERNELS);

  load_state_e           state_q;
  logic                  busy_q, done_q, err_q, valid_q, rd_en_q, fen_q;
  logic [KIDX_WIDTH-1:0] kidx_q, loaded_idx_q;
  logic                  idx_ok, accept, tap_last;

  assign idx_ok = ({1'b0, kernel_idx_i} < NUM_K);
  assign accept = ((state_q == IDLE) || (state_q == READY)) && load_req_i && idx_ok;

  wm_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .KIDX_WIDTH(KIDX_WIDTH),
    .TAPS      (TAPS),
    .CNT_WIDTH (tap_cnt_width(TAPS))
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .start_i     (accept),
    .kernel_idx_i(kernel_idx_i),
    .advance_i   (state_q == FETCH),
    .addr_o      (mem_addr_o),
    .last_o      (tap_last)
  );

  // Requests arriving during FETCH/DRAIN fall through the case and are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      fen_q        <= 1'b0;
      kidx_q       <= '0;
      loaded_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      fen_q  <= rd_en_q;
      case (state_q)
        IDLE, READY: begin
          if (accept) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            valid_q <= 1'b0;
            kidx_q  <= kernel_idx_i;
          end else if (load_req_i) begin
            err_q <= 1'b1;
          end
        end
        FETCH: begin
          if (tap_last) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end
        end
        DRAIN: begin
          state_q      <= READY;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          valid_q      <= 1'b1;
          loaded_idx_q <= kidx_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_busy_o     = busy_q;
  assign load_done_o     = done_q;
  assign req_err_o       = err_q;
  assign weights_valid_o = valid_q;
  assign loaded_idx_o    = loaded_idx_q;
  assign mem_rd_en_o     = rd_en_q;
  assign fifo_enable_o   = fen_q;
  assign fifo_data_in_o  = mem_rd_data_i;

`ifdef WM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (accept) checksum_d = '0;
    else if (fen_q) checksum_d = checksum_q + mem_rd_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) checksum_q <= '0;
    else checksum_q <= checksum_d;
  end

  assign load_checksum_o = checksum_q;
`else
  // Checksum build option disabled: no accumulator.
`endif

endmodule

// File: tb/tb_wm_fifo_load_ctrl.sv
// Self-checking bench for wm_fifo_load_ctrl: vector table of kernel loads and
// rejects, plus held-request and mid-load reset sequences; FIFO words scoreboarded.
module tb_wm_fifo_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic [2:0]  kernel_idx;
  logic        load_busy, load_done, req_err, weights_valid;
  logic [2:0]  loaded_idx;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rd_data = '0;
  logic        fifo_enable;
  logic [31:0] fifo_data_in;
`ifdef WM_CHECKSUM_EN
  logic [31:0] load_checksum;
`endif

  int n_vec = 0;
  int n_err = 0;
  int en_count = 0;
  logic [31:0] sb_q[$];
  logic [31:0] fifo_m[25];

  always #5 clk = ~clk;

  wm_fifo_load_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .load_req_i     (load_req),
    .kernel_idx_i   (kernel_idx),
    .load_busy_o    (load_busy),
    .load_done_o    (load_done),
    .req_err_o      (req_err),
    .weights_valid_o(weights_valid),
    .loaded_idx_o   (loaded_idx),
    .mem_rd_en_o    (mem_rd_en),
    .mem_addr_o     (mem_addr),
    .mem_rd_data_i  (mem_rd_data),
    .fifo_enable_o  (fifo_enable),
    .fifo_data_in_o (fifo_data_in)
`ifdef WM_CHECKSUM_EN
    ,
    .load_checksum_o(load_checksum)
`endif
  );

  // Memory model: word at address a is a+1, one cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= {24'd0, mem_addr} + 32'd1;

  // 25-output FIFO model: first word shifted ends up on out_1 (fifo_m[0]).
  always @(posedge clk) begin
    if (fifo_enable) begin
      for (int i = 0; i < 24; i++) fifo_m[i] <= fifo_m[i + 1];
      fifo_m[24] <= fifo_data_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Scoreboard: every shift strobe must match the next expected word.
  always @(negedge clk) begin
    if (fifo_enable === 1'b1) begin
      en_count++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL fifo_unexpected: got fifo_enable with data %0d, expected no shift at %0t", fifo_data_in, $time);
      end else begin
        chk("fifo_data", fifo_data_in, sb_q.pop_front());
      end
    end
  end

  task automatic push_kernel(input int base);
    for (int k = 1; k <= 25; k++) sb_q.push_back(32'(base + k));
  endtask

  function automatic logic [4:0] ctl_exp(input int c);
    return {c <= 26, c <= 25, (c >= 2) && (c <= 26), c == 27, c == 27};
  endfunction

  // Drive an accepted request at the current negedge and check cycles 1..27.
  task automatic run_load(input logic [2:0] idx, input logic [31:0] out1,
                          input logic [31:0] out25, input logic [31:0] sum);
    int base;
    int en0;
    base = int'(idx) * 25;
    en0  = en_count;
    push_kernel(base);
    load_req   = 1'b1;
    kernel_idx = idx;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      load_req = 1'b0;
      chk($sformatf("ctl_k%0d_c%0d", idx, c),
          {27'd0, load_busy, mem_rd_en, fifo_enable, load_done, weights_valid},
          {27'd0, ctl_exp(c)});
      if (c <= 25) chk("mem_addr", {24'd0, mem_addr}, 32'(base + c - 1));
      if (c == 1) chk("no_err_on_accept", {31'd0, req_err}, 32'd0);
    end
    chk("loaded_idx", {29'd0, loaded_idx}, {29'd0, idx});
    chk("fen_pulses", 32'(en_count - en0), 32'd25);
    chk("fifo_out_1", fifo_m[0], out1);
    chk("fifo_out_25", fifo_m[24], out25);
`ifdef WM_CHECKSUM_EN
    chk("checksum", load_checksum, sum);
`else
    if (sum == 32'hFFFF_FFFF) $display("unused checksum expectation");
`endif
  endtask

  task automatic run_err(input logic [2:0] idx, input logic exp_valid);
    load_req   = 1'b1;
    kernel_idx = idx;
    @(negedge clk);
    load_req = 1'b0;
    chk($sformatf("err_pulse_k%0d", idx), {29'd0, req_err, load_busy, mem_rd_en}, 32'b100);
    chk("err_valid_kept", {31'd0, weights_valid}, {31'd0, exp_valid});
    @(negedge clk);
    chk("err_one_cycle", {29'd0, req_err, load_busy, mem_rd_en}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  idx;
    logic        is_err;
    logic        valid_before;
    logic [31:0] out1;
    logic [31:0] out25;
    logic [31:0] sum;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int rd_cnt;
    int en0;
    vecs[0] = '{3'd6, 1'b1, 1'b0, 32'd0,   32'd0,   32'd0};
    vecs[1] = '{3'd0, 1'b0, 1'b0, 32'd1,   32'd25,  32'd325};
    vecs[2] = '{3'd5, 1'b0, 1'b1, 32'd126, 32'd150, 32'd3450};
    vecs[3] = '{3'd6, 1'b1, 1'b1, 32'd0,   32'd0,   32'd0};
    vecs[4] = '{3'd7, 1'b1, 1'b1, 32'd0,   32'd0,   32'd0};
    vecs[5] = '{3'd4, 1'b0, 1'b1, 32'd101, 32'd125, 32'd2825};

    reset      = 1'b1;
    load_req   = 1'b0;
    kernel_idx = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {19'd0, load_busy, load_done, req_err, weights_valid, loaded_idx, mem_rd_en, fifo_enable},
        32'd0);
    chk("reset_addr", {24'd0, mem_addr}, 32'd0);
`ifdef WM_CHECKSUM_EN
    chk("reset_checksum", load_checksum, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].is_err) run_err(vecs[i].idx, vecs[i].valid_before);
      else run_load(vecs[i].idx, vecs[i].out1, vecs[i].out25, vecs[i].sum);
    end

    // load_req held high: one sequence, then re-accept at the first READY edge.
    en0    = en_count;
    rd_cnt = 0;
    push_kernel(50);
    load_req   = 1'b1;
    kernel_idx = 3'd2;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (mem_rd_en) rd_cnt++;
      if (req_err) chk("held_no_err", {31'd0, req_err}, 32'd0);
    end
    chk("held_rd_pulses", 32'(rd_cnt), 32'd25);
    chk("held_done", {30'd0, load_done, weights_valid}, 32'b11);
    push_kernel(50);
    @(negedge clk);
    load_req = 1'b0;
    chk("held_reaccept", {29'd0, load_busy, mem_rd_en, weights_valid}, 32'b110);
    chk("held_reaccept_addr", {24'd0, mem_addr}, 32'd50);
    repeat (26) @(negedge clk);
    chk("held_second_done", {31'd0, load_done}, 32'd1);
    chk("held_fen_pulses", 32'(en_count - en0), 32'd50);

    // Reset during cycle 10 of a kernel-3 load aborts it.
    push_kernel(75);
    load_req   = 1'b1;
    kernel_idx = 3'd3;
    @(negedge clk);
    load_req = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_outputs", {19'd0, load_busy, load_done, req_err, weights_valid, loaded_idx, mem_rd_en, fifo_enable},
        32'd0);
    chk("abort_addr", {24'd0, mem_addr}, 32'd0);
    sb_q.delete();
    en0 = en_count;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_fen", 32'(en_count - en0), 32'd0);
    chk("abort_valid_low", {31'd0, weights_valid}, 32'd0);
    run_load(3'd1, 32'd26, 32'd50, 32'd950);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
